program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Boot-side stage upstream of cpu_sequential: accepts a program as a valid/ready word stream and writes it into the CPU instruction memory.
// - Holds the CPU in reset during load, writes a 32'h0 halt sentinel after the last word, then releases the CPU.
// - Watches the fetched instruction for the all-zero halt word and reports halt and run-cycle count to the bench.
// PARAMETERS
// - ADDR_WIDTH      8     imem word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH
// - DATA_WIDTH      32    instruction word width
// - TIMEOUT_CYCLES  4096  watchdog limit in RUN cycles; used only with LOADER_TIMEOUT_EN
// PORTS
// - clk             in   1           rising-edge clock
// - reset           in   1           asynchronous, active-low reset
// - s_valid         in   1           program word valid
// - s_ready         out  1           loader can accept a word
// - s_data          in   DATA_WIDTH  program word
// - s_last          in   1           qualifies the final word of the program
// - imem_we         out  1           instruction-memory write strobe
// - imem_addr       out  ADDR_WIDTH  word address; the CPU byte PC maps to imem_addr*4
// - imem_wdata      out  DATA_WIDTH  instruction word to write
// - cpu_reset       out  1           active-high reset to cpu_sequential
// - cpu_instruction in   DATA_WIDTH  instruction currently fetched by the CPU
// - halted          out  1           sticky: halt word fetched, or timeout
// - overflow        out  1           sticky: program exceeded MAX_WORDS
// - words_loaded    out  ADDR_WIDTH+1  number of program words written, excluding the sentinel
// - run_cycles      out  32          clk cycles spent in RUN
// BEHAVIOUR
// - Reset (async, reset=0) values:
//   - state=LOAD, s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1.
//   - halted=0, overflow=0, words_loaded=0, run_cycles=0.
// - All outputs are registered. Handshake: a beat is accepted on the rising edge where s_valid&s_ready=1.
// - LOAD:
//   - Each accepted beat produces imem_we=1, imem_addr=words_loaded, imem_wdata=s_data in the next cycle (1-cycle latency); words_loaded increments.
//   - Accepted beat with s_last=1: s_ready drops the next cycle and the FSM goes to TERM.
//   - Accepted beat at address MAX_WORDS-1 with s_last=0: overflow=1, the beat is treated as last, and the FSM goes to RELEASE; no sentinel is written.
// - TERM: one cycle with imem_we=1, imem_addr=words_loaded, imem_wdata=0; the FSM goes to RELEASE.
// - RELEASE: one cycle with imem_we=0 and cpu_reset still 1, so the final write settles before the first fetch; the FSM goes to RUN.
// - RUN:
//   - cpu_reset=0; run_cycles increments every cycle.
//   - The first RUN cycle ignores cpu_instruction, because the PC is still settling after reset.
//   - From the second RUN cycle, cpu_instruction==0 sets halted=1 and moves the FSM to HALT in the same edge.
// - HALT:
//   - Terminal state; s_ready=0 and imem_we=0.
//   - cpu_reset stays 0, so register and memory contents remain readable; run_cycles is frozen.
//   - Only reset leaves HALT.
// - s_valid is ignored outside LOAD; s_ready is 1 only in LOAD.
// - A zero-length program is impossible; at least one beat is required.
// - Reset mid-load or mid-run:
//   - All state returns to the reset values immediately.
//   - Partially written imem contents are not cleared; the next load overwrites them from address 0.
// - Widths: words_loaded saturates at MAX_WORDS; run_cycles wraps at 2**32.
// CONFIGURATION
// - LOADER_TIMEOUT_EN defined:
//   - In RUN, when run_cycles reaches TIMEOUT_CYCLES-1 without a halt word, halted=1 and the FSM goes to HALT.
//   - An extra output, timeout (1 bit, reset 0, sticky), is set alongside halted.
// - LOADER_TIMEOUT_EN undefined: there is no watchdog and no timeout port; RUN persists until a halt word is fetched or reset is asserted.
// TESTING
// - Six-word program (0x00000513, 0x00052583, 0x00852603, 0x00850513, 0x00052683, 0x00000000), s_last on the sixth word, s_valid held high:
//   - Required: imem writes at addresses 0..5, then sentinel 0 at address 6.
//   - Required: words_loaded=6, cpu_reset falls 2 cycles after the TERM write, halted=1 when the CPU fetches word 5.
// - Same program with s_valid toggling every other cycle: identical imem contents; no beat is lost or duplicated.
// - MAX_WORDS=256 nonzero words with no s_last: overflow=1, words_loaded=256, no sentinel write, cpu_reset is released.
// - Reset asserted after 3 of 6 beats, then a full reload: words_loaded=6, imem addresses 0..5 hold the new words, halted=0 until the new halt word.
// - Beat with s_valid=1 presented during RUN: s_ready=0 and no imem_we pulse.
// - LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and an endless-loop program (0x00000063, beq x0,x0,0): after 16 RUN cycles halted=1, timeout=1, run_cycles=16.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: streams a program into instruction memory, appends a halt sentinel, releases the CPU and watches for the halt word.
// Optional RUN watchdog with a sticky timeout output is built when LOADER_TIMEOUT_EN is defined.
module program_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
`ifdef LOADER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_reset,
   input  logic [DATA_WIDTH-1:0] cpu_instruction,
   output logic                  halted,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic [31:0]           run_cycles
`ifdef LOADER_TIMEOUT_EN
   ,
   output logic                  timeout
`endif
);

   localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(MAX_WORDS - 1);

   localparam logic [2:0] LOAD    = 3'd0;
   localparam logic [2:0] TERM    = 3'd1;
   localparam logic [2:0] RELEASE = 3'd2;
   localparam logic [2:0] RUN     = 3'd3;
   localparam logic [2:0] HALT    = 3'd4;

   logic [2:0] state;
   logic       first_run;

   // Every output is a register; each state schedules what the next cycle shows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= LOAD;
         first_run    <= 1'b0;
         s_ready      <= 1'b1;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_reset    <= 1'b1;
         halted       <= 1'b0;
         overflow     <= 1'b0;
         words_loaded <= '0;
         run_cycles   <= '0;
`ifdef LOADER_TIMEOUT_EN
         timeout      <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               imem_we <= 1'b0;
               if (s_valid && s_ready) begin
                  imem_we      <= 1'b1;
                  imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                  imem_wdata   <= s_data;
                  words_loaded <= words_loaded + 1'b1;
                  // A beat landing in the top word leaves no room for a sentinel, whether or not it was marked last.
                  if (words_loaded == LAST_ADDR) begin
                     s_ready  <= 1'b0;
                     overflow <= !s_last;
                     state    <= RELEASE;
                  end else if (s_last) begin
                     s_ready <= 1'b0;
                     state   <= TERM;
                  end
               end
            end
            TERM: begin
               imem_we    <= 1'b1;
               imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
               imem_wdata <= '0;
               state      <= RELEASE;
            end
            RELEASE: begin
               imem_we   <= 1'b0;
               first_run <= 1'b1;
               state     <= RUN;
            end
            RUN: begin
               cpu_reset  <= 1'b0;
               first_run  <= 1'b0;
               run_cycles <= run_cycles + 32'd1;
               // The first RUN cycle still has the CPU in reset, so its fetch is meaningless.
               if (!first_run && cpu_instruction == '0) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end
`ifdef LOADER_TIMEOUT_EN
               else if (run_cycles == 32'(TIMEOUT_CYCLES - 1)) begin
                  halted  <= 1'b1;
                  timeout <= 1'b1;
                  state   <= HALT;
               end
`endif
            end
            HALT: begin
               s_ready <= 1'b0;
               imem_we <= 1'b0;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a toy CPU/imem model plus randomized program loads.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic [31:0] cpu_instruction;
   logic        halted;
   logic        overflow;
   logic [8:0]  words_loaded;
   logic [31:0] run_cycles;
`ifdef LOADER_TIMEOUT_EN
   logic        timeout;
`endif

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [256];
   logic [7:0]  pc = 8'd0;
   logic [31:0] prog [$];
   logic [7:0]  log_addr [$];
   logic [31:0] log_data [$];
   int          log_cyc [$];
   int          cyc = 0;
   int          fall_cyc = 0;

   program_loader #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32)
`ifdef LOADER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .s_last(s_last),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset),
      .cpu_instruction(cpu_instruction),
      .halted(halted),
      .overflow(overflow),
      .words_loaded(words_loaded),
      .run_cycles(run_cycles)
`ifdef LOADER_TIMEOUT_EN
      ,
      .timeout(timeout)
`endif
   );

   always #5 clk = ~clk;

   // Toy CPU: linear fetch, except beq x0,x0,0 which spins in place.
   assign cpu_instruction = mem[pc];
   always @(posedge clk) begin
      pc <= cpu_reset ? 8'd0 : ((cpu_instruction == 32'h0000_0063) ? pc : pc + 8'd1);
   end

   // Instruction memory and write/release monitor, sampled mid-cycle.
   initial begin
      logic prev_rst;
      prev_rst = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
      forever begin
         @(negedge clk);
         cyc++;
         if (imem_we === 1'b1) begin
            mem[imem_addr] = imem_wdata;
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cyc);
         end
         if (prev_rst === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
         prev_rst = cpu_reset;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 32'h0;
      reset   = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic applyStimulus(input int n, input int mode, input bit use_last, output int accepted);
      int  k;
      bit  acc;
      k = 0;
      accepted = 0;
      while (accepted < n && s_ready === 1'b1 && k < 4000) begin
         case (mode)
            0:       s_valid = 1'b1;
            1:       s_valid = (k % 2 == 0);
            default: s_valid = ($urandom_range(0, 3) != 0);
         endcase
         s_data = s_valid ? prog[accepted] : $urandom;
         s_last = s_valid ? (use_last && accepted == n - 1) : 1'($urandom);
         acc = s_valid && s_ready;
         step();
         if (acc) accepted++;
         k++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 32'h0;
   endtask

   task automatic wait_cpu_run(input string label, input int budget);
      int k;
      k = 0;
      while (cpu_reset !== 1'b0 && k < budget) begin
         step();
         k++;
      end
      tests++;
      if (cpu_reset !== 1'b0) begin
         fails++;
         $display("[TB] FAIL %s cpu_reset release: got %b want 0 within %0d cycles", label, cpu_reset, budget);
      end
   endtask

   task automatic wait_halt(input string label, input int budget);
      int k;
      k = 0;
      while (halted !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      tests++;
      if (halted !== 1'b1) begin
         fails++;
         $display("[TB] FAIL %s halt: got halted=%b want 1 within %0d cycles", label, halted, budget);
      end
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      step();
      tests++;
      if ({s_ready, imem_we, cpu_reset, halted, overflow} !== 5'b10100) begin
         fails++;
         $display("[TB] FAIL reset flags: got ready/we/cpu_rst/halt/ovf=%b want 10100",
                  {s_ready, imem_we, cpu_reset, halted, overflow});
      end
      tests++;
      if (imem_addr !== 8'h0 || imem_wdata !== 32'h0) begin
         fails++;
         $display("[TB] FAIL reset imem bus: got addr=%h data=%h want 00/00000000", imem_addr, imem_wdata);
      end
      tests++;
      if (words_loaded !== 9'd0 || run_cycles !== 32'd0) begin
         fails++;
         $display("[TB] FAIL reset counters: got words=%0d run=%0d want 0/0", words_loaded, run_cycles);
      end
`ifdef LOADER_TIMEOUT_EN
      tests++;
      if (timeout !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset timeout: got %b want 0", timeout);
      end
`endif
      reset = 1'b1;
   endtask

   // Loads prog with s_last on the final word and checks writes, release timing and halt.
   task automatic test_program(input string label, input int mode);
      int          n, start, acc, h, exp_run;
      logic [31:0] exp_d;
      n = prog.size();
      do_reset();
      start = log_addr.size();
      applyStimulus(n, mode, 1'b1, acc);
      tests++;
      if (acc != n) begin
         fails++;
         $display("[TB] FAIL %s beats accepted: got %0d want %0d", label, acc, n);
      end
      wait_cpu_run(label, 40);
      tests++;
      if (log_addr.size() - start != n + 1) begin
         fails++;
         $display("[TB] FAIL %s write count: got %0d want %0d", label, log_addr.size() - start, n + 1);
      end else begin
         for (int i = 0; i <= n; i++) begin
            exp_d = (i < n) ? prog[i] : 32'h0;
            tests++;
            if (log_addr[start + i] !== 8'(i) || log_data[start + i] !== exp_d) begin
               fails++;
               $display("[TB] FAIL %s write %0d: got addr=%0d data=%h want addr=%0d data=%h",
                        label, i, log_addr[start + i], log_data[start + i], i, exp_d);
            end
         end
         tests++;
         if (fall_cyc - log_cyc[start + n] != 2) begin
            fails++;
            $display("[TB] FAIL %s release delay: got %0d want 2 cycles after sentinel",
                     label, fall_cyc - log_cyc[start + n]);
         end
      end
      tests++;
      if (words_loaded !== 9'(n)) begin
         fails++;
         $display("[TB] FAIL %s words_loaded: got %0d want %0d", label, words_loaded, n);
      end
      h = n;
      for (int i = n - 1; i >= 0; i--) if (prog[i] == 32'h0) h = i;
      exp_run = h + 2;
      wait_halt(label, exp_run + 20);
      tests++;
      if (run_cycles !== 32'(exp_run)) begin
         fails++;
         $display("[TB] FAIL %s run_cycles: got %0d want %0d", label, run_cycles, exp_run);
      end
      tests++;
      if ({halted, overflow, cpu_reset, s_ready, imem_we} !== 5'b10000) begin
         fails++;
         $display("[TB] FAIL %s halt status: got halt/ovf/cpu_rst/ready/we=%b want 10000", label,
                  {halted, overflow, cpu_reset, s_ready, imem_we});
      end
      repeat (4) step();
      tests++;
      if (run_cycles !== 32'(exp_run)) begin
         fails++;
         $display("[TB] FAIL %s run_cycles frozen: got %0d want %0d", label, run_cycles, exp_run);
      end
   endtask

   task automatic load_six_word();
      prog.delete();
      prog.push_back(32'h0000_0513);
      prog.push_back(32'h0005_2583);
      prog.push_back(32'h0085_2603);
      prog.push_back(32'h0085_0513);
      prog.push_back(32'h0005_2683);
      prog.push_back(32'h0000_0000);
   endtask

   task automatic test_six_word();
      load_six_word();
      test_program("six_word", 0);
   endtask

   task automatic test_toggle();
      load_six_word();
      test_program("toggle", 1);
   endtask

   task automatic test_random();
      int          n;
      logic [31:0] w;
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, 12);
         prog.delete();
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == 32'h0) w = 32'h1;
            prog.push_back(w);
         end
         if ($urandom_range(0, 2) == 0) prog[$urandom_range(0, n - 1)] = 32'h0;
         test_program($sformatf("random%0d", r), 2);
      end
   endtask

   task automatic test_overflow();
      int          start, acc, bad;
      logic [31:0] w;
      prog.delete();
      for (int i = 0; i < 300; i++) begin
         w = $urandom;
         if (w == 32'h0) w = 32'h5;
         prog.push_back(w);
      end
      do_reset();
      start = log_addr.size();
      applyStimulus(300, 0, 1'b0, acc);
      tests++;
      if (acc != 256) begin
         fails++;
         $display("[TB] FAIL overflow beats accepted: got %0d want 256", acc);
      end
      wait_cpu_run("overflow", 40);
      tests++;
      if (overflow !== 1'b1 || words_loaded !== 9'd256) begin
         fails++;
         $display("[TB] FAIL overflow flags: got ovf=%b words=%0d want 1/256", overflow, words_loaded);
      end
      bad = 0;
      if (log_addr.size() - start != 256) bad = 1000;
      else
         for (int i = 0; i < 256; i++)
            if (log_addr[start + i] !== 8'(i) || log_data[start + i] !== prog[i]) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("[TB] FAIL overflow writes: got %0d writes with %0d bad want 256 with 0 bad (no sentinel)",
                  log_addr.size() - start, bad);
      end
      repeat (5) step();
      tests++;
      if (halted !== 1'b0) begin
         fails++;
         $display("[TB] FAIL overflow halted: got %b want 0", halted);
      end
   endtask

   task automatic test_mid_reset();
      int          start, acc;
      logic [31:0] w;
      prog.delete();
      for (int i = 0; i < 6; i++) prog.push_back($urandom | 32'h1);
      do_reset();
      applyStimulus(3, 0, 1'b0, acc);
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if ({s_ready, imem_we, cpu_reset} !== 3'b101 || words_loaded !== 9'd0) begin
         fails++;
         $display("[TB] FAIL mid_reset async: got ready/we/cpu_rst=%b words=%0d want 101/0",
                  {s_ready, imem_we, cpu_reset}, words_loaded);
      end
      step();
      reset = 1'b1;
      prog.delete();
      for (int i = 0; i < 5; i++) begin
         w = $urandom;
         if (w == 32'h0) w = 32'h9;
         prog.push_back(w);
      end
      prog.push_back(32'h0);
      start = log_addr.size();
      applyStimulus(6, 0, 1'b1, acc);
      wait_cpu_run("mid_reset", 40);
      tests++;
      if (halted !== 1'b0 || words_loaded !== 9'd6) begin
         fails++;
         $display("[TB] FAIL mid_reset reload: got halted=%b words=%0d want 0/6", halted, words_loaded);
      end
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (mem[i] !== prog[i]) begin
            fails++;
            $display("[TB] FAIL mid_reset imem[%0d]: got %h want %h", i, mem[i], prog[i]);
         end
      end
      wait_halt("mid_reset", 30);
      tests++;
      if (run_cycles !== 32'd7 || log_addr.size() - start != 7) begin
         fails++;
         $display("[TB] FAIL mid_reset run: got run=%0d writes=%0d want 7/7", run_cycles, log_addr.size() - start);
      end
   endtask

   task automatic test_valid_in_run();
      int          start, acc;
      logic [31:0] w;
      prog.delete();
      for (int i = 0; i < 10; i++) begin
         w = $urandom;
         if (w == 32'h0) w = 32'h3;
         prog.push_back(w);
      end
      do_reset();
      start = log_addr.size();
      applyStimulus(10, 0, 1'b1, acc);
      wait_cpu_run("valid_in_run", 40);
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = $urandom;
         s_last  = 1'($urandom);
         step();
         tests++;
         if (s_ready !== 1'b0 || imem_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL valid_in_run cycle %0d: got ready=%b we=%b want 0/0", i, s_ready, imem_we);
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      wait_halt("valid_in_run", 40);
      tests++;
      if (run_cycles !== 32'd12 || log_addr.size() - start != 11) begin
         fails++;
         $display("[TB] FAIL valid_in_run end: got run=%0d writes=%0d want 12/11", run_cycles, log_addr.size() - start);
      end
   endtask

`ifdef LOADER_TIMEOUT_EN
   task automatic test_timeout();
      int acc;
      prog.delete();
      prog.push_back(32'h0000_0063);
      do_reset();
      applyStimulus(1, 0, 1'b1, acc);
      wait_cpu_run("timeout", 40);
      wait_halt("timeout", 60);
      tests++;
      if (timeout !== 1'b1 || run_cycles !== 32'd16) begin
         fails++;
         $display("[TB] FAIL timeout: got timeout=%b run=%0d want 1/16", timeout, run_cycles);
      end
   endtask
`endif

   initial begin
      reset   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 32'h0;
      test_reset();
      test_six_word();
      test_toggle();
      test_random();
      test_overflow();
      test_mid_reset();
      test_valid_in_run();
`ifdef LOADER_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
